sha256d_nonce_sched: RTL
========================

# sha256d_nonce_sched

Nonce-sweep controller for the double-SHA-256 header hasher. Holds a 19-word Bitcoin block-header template plus a target, and launches one `sha256d_wrapper` hash per nonce over an inclusive range. It serves the hasher's word-request bus, compares each result against the target, and stops on the first winning nonce, on range exhaustion, or on abort. It sits between the host register file and the single shared hasher instance.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: template write strobe; ignored while `busy`.
- `cfg_addr` in 5: template word index 0..18; writes to 19..31 are ignored.
- `cfg_wdata` in 32: template word.
- `target` in 256: difficulty target; must be stable while `busy`.
- `nonce_first` / `nonce_last` in 32 each: inclusive sweep bounds, sampled on `start`.
- `start` in 1: single-cycle pulse that begins a sweep; ignored while `busy`.
- `abort` in 1: single-cycle pulse requesting an early stop.
- `core_start` out 1: single-cycle launch pulse to the hasher.
- `core_addr` in 5 / `core_rq` in 1: word request from the hasher.
- `core_rdy` out 1 / `core_data` out 32: word response to the hasher.
- `core_hash` in 256 / `core_done` in 1: hasher result and its one-cycle completion pulse.
- `busy` out 1: a sweep is active.
- `found` out 1: the last sweep hit; sticky until the next `start`.
- `exhausted` out 1: the last sweep ended without a hit; sticky until the next `start`.
- `win_nonce` out 32: the winning nonce.
- `win_hash` out 256: the winning hash.
- `cur_nonce` out 32: the nonce currently being hashed.
- `hash_count` out 32: hashes completed in the current sweep; saturates at FFFFFFFF.

## Operation
- Template: 19 × 32-bit registers, reset to 0.
- Word map for hasher requests:
  - Addresses 0..18 return the template word.
  - Address 19 returns `cur_nonce`.
  - Address 20 returns 32'h80000000.
  - All other addresses return 0.
- FSM states: IDLE, LAUNCH, WAIT, CHECK, DRAIN.
  - IDLE, on `start`:
    - Clear `found`, `exhausted` and `hash_count`.
    - If `nonce_first > nonce_last` (unsigned): set `exhausted`, stay IDLE, issue no hash.
    - Otherwise load `cur_nonce = nonce_first` and go to LAUNCH.
  - LAUNCH: assert `core_start` for exactly one cycle, then go to WAIT.
  - WAIT: on `core_done`, register `core_hash`, increment `hash_count`, go to CHECK. If an abort is pending, go to DRAIN instead of CHECK.
  - CHECK: compare `byte_reverse(core_hash) < target` (unsigned 256-bit, Bitcoin little-endian convention).
    - Hit: latch `win_nonce` and `win_hash`, set `found`, go to IDLE.
    - Miss with `cur_nonce == nonce_last`: set `exhausted`, go to IDLE.
    - Otherwise: `cur_nonce += 1`, go to LAUNCH.
  - DRAIN: set `exhausted`, go to IDLE.
- Abort handling:
  - `abort` in LAUNCH or WAIT latches a pending flag. The current hash runs to completion because the hasher cannot be cancelled; its result is discarded.
  - `abort` in CHECK takes effect before the next LAUNCH; a hit in that same CHECK still wins.
  - `abort` in IDLE is ignored.
- Wrap-around: `nonce_last = FFFFFFFF` terminates on equality; `cur_nonce` never wraps to 0.
- `core_done` outside WAIT is ignored.
- `busy` is high in every state except IDLE.

## Timing
- Request handshake: `core_rdy` is `core_rq` registered (1-cycle latency). `core_data` is registered from `core_addr` in the same cycle. `core_rdy` stays high while `core_rq` stays high.
- `start` → `core_start`: 2 cycles (IDLE→LAUNCH, LAUNCH asserts).
- `core_done` → next `core_start` on a miss: 3 cycles (WAIT→CHECK→LAUNCH, then assert).
- `core_done` → `found` or `exhausted`: 2 cycles.
- Reset values:
  - All outputs 0, including `core_start` and `core_rdy`.
  - FSM in IDLE, pending-abort flag clear.
- Reset mid-sweep: everything returns to reset values immediately. The hasher is reset by the same source.
- `cfg_we` and `start` in the same cycle while IDLE: both take effect; the write is visible to the new sweep.

## Configuration
- `NONCE_BSWAP_EN` defined: address 19 returns `cur_nonce` byte-swapped, matching the raw header byte order. `win_nonce` and `cur_nonce` stay unswapped.
- `NONCE_BSWAP_EN` undefined: address 19 returns `cur_nonce` unmodified.

## Structure
- Shared package `sha256d_pkg` holds:
  - FSM state enum.
  - Header word count (19), nonce word index (19), pad word index (20) and pad constant.
  - The `byte_reverse256` function.
- One sub-module, `hash_target_cmp`: registered 256-bit byte-reversed less-than comparator.

## Test plan
- Template words i = 32'h01010101 × i, range 5..5; hasher model returns hash 0 (byte-reversed 0 < target 1) → one `core_start`; request at address 19 returns 5; `found` = 1, `win_nonce` = 5, `hash_count` = 1.
- Range 10..13, model returns all-ones hash, target = 2^224 → four launches with nonces 10, 11, 12, 13; `exhausted` = 1, `hash_count` = 4.
- Range FFFFFFFE..FFFFFFFF, all misses → exactly two hashes; `cur_nonce` ends at FFFFFFFF; `exhausted` = 1.
- `abort` pulsed during WAIT of nonce 3 in range 0..100, model would report a hit at nonce 3 → no further launches; `found` = 0, `exhausted` = 1.
- `rst` asserted during WAIT → all outputs 0 on the next edge; a later `start` with range 7..7 behaves normally.
- Requests at addresses 20, 21 and 31 → data 80000000, 0, 0 with `core_rdy` one cycle after `core_rq`. With `NONCE_BSWAP_EN` and nonce 12345678, address 19 → 78563412.

Source files
------------

// File: rtl/sha256d_pkg.sv
// Shared definitions for the double-SHA-256 nonce sweep controller.
//   state_t          : sweep controller FSM states
//   HDR_WORDS        : number of template words held (19)
//   NONCE_IDX        : hasher word index that carries the nonce (19)
//   PAD_IDX/PAD_WORD : hasher word index of the first padding word and its value
//   byte_reverse256  : reverses the byte order of a 256-bit value
package sha256d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_DRAIN
    } state_t;

    localparam logic [4:0]  HDR_WORDS = 5'd19;
    localparam logic [4:0]  NONCE_IDX = 5'd19;
    localparam logic [4:0]  PAD_IDX   = 5'd20;
    localparam logic [31:0] PAD_WORD  = 32'h8000_0000;

    function automatic logic [255:0] byte_reverse256(input logic [255:0] v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = v[8*(31-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// Registered 256-bit comparator: captures a hasher result and whether its
// byte-reversed value (Bitcoin little-endian reading) is below the target.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : capture strobe (one cycle per completed hash)
//   hash     : raw hasher output
//   target   : difficulty target, stable while a sweep runs
//   lt       : registered byte_reverse(hash) < target
//   hash_q   : registered copy of hash
module hash_target_cmp
    import sha256d_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [255:0] hash,
    input  logic [255:0] target,
    output logic         lt,
    output logic [255:0] hash_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lt     <= 1'b0;
            hash_q <= '0;
        end else if (en) begin
            lt     <= (byte_reverse256(hash) < target);
            hash_q <= hash;
        end
    end

endmodule

// File: rtl/sha256d_nonce_sched.sv
// Nonce-sweep controller for the shared double-SHA-256 header hasher.
// Holds a 19-word header template, launches one hash per nonce over an
// inclusive range, serves the hasher's word requests and stops on the first
// hash below target, on range exhaustion, or on abort.
// Build option: NONCE_BSWAP_EN - word 19 is served byte-swapped (raw header
// byte order); win_nonce and cur_nonce remain unswapped.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_wdata       : template write port (ignored while busy)
//   target                          : difficulty target
//   nonce_first/nonce_last          : inclusive sweep bounds, sampled on start
//   start, abort                    : sweep control pulses
//   core_start                      : one-cycle hash launch pulse
//   core_addr/core_rq               : hasher word request
//   core_rdy/core_data              : registered word response
//   core_hash/core_done             : hasher result and completion pulse
//   busy, found, exhausted          : sweep status
//   win_nonce/win_hash              : winning nonce and hash
//   cur_nonce, hash_count           : nonce being hashed, hashes completed
//
// state  | meaning
// IDLE   | no sweep; waits for start
// LAUNCH | issues core_start for the current nonce
// WAIT   | hasher running; waits for core_done
// CHECK  | compares registered result against target
// DRAIN  | aborted hash has completed; close the sweep
module sha256d_nonce_sched
    import sha256d_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [4:0]   cfg_addr,
    input  logic [31:0]  cfg_wdata,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_first,
    input  logic [31:0]  nonce_last,
    input  logic         start,
    input  logic         abort,
    output logic         core_start,
    input  logic [4:0]   core_addr,
    input  logic         core_rq,
    output logic         core_rdy,
    output logic [31:0]  core_data,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  win_nonce,
    output logic [255:0] win_hash,
    output logic [31:0]  cur_nonce,
    output logic [31:0]  hash_count
);

    state_t state, state_nxt;

    logic [31:0]  tmpl [HDR_WORDS];
    logic [31:0]  last_q;
    logic         pending;
    logic         cmp_lt;
    logic [255:0] cmp_hash;
    logic [31:0]  nonce_word;
    logic [31:0]  word_sel;

    logic core_start_nxt;
    logic sweep_go;
    logic sweep_empty;
    logic take_hash;
    logic set_found;
    logic set_exh;
    logic step;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        core_start_nxt = 1'b0;
        sweep_go       = 1'b0;
        sweep_empty    = 1'b0;
        take_hash      = 1'b0;
        set_found      = 1'b0;
        set_exh        = 1'b0;
        step           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (nonce_first > nonce_last) begin
                        sweep_empty = 1'b1;
                    end else begin
                        sweep_go  = 1'b1;
                        state_nxt = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                core_start_nxt = 1'b1;
                state_nxt      = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    take_hash = 1'b1;
                    // An abort arriving with the completion still discards it.
                    state_nxt = (pending || abort) ? ST_DRAIN : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cmp_lt) begin
                    set_found = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cur_nonce == last_q) begin
                    set_exh   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (abort) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    step      = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_DRAIN: begin
                set_exh   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    hash_target_cmp u_cmp (
        .clk    (clk),
        .rst    (rst),
        .en     (take_hash),
        .hash   (core_hash),
        .target (target),
        .lt     (cmp_lt),
        .hash_q (cmp_hash)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_start <= 1'b0;
            pending    <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            win_nonce  <= '0;
            win_hash   <= '0;
            cur_nonce  <= '0;
            last_q     <= '0;
            hash_count <= '0;
        end else begin
            core_start <= core_start_nxt;

            if (state_nxt == ST_IDLE)
                pending <= 1'b0;
            else if (abort && (state == ST_LAUNCH || state == ST_WAIT))
                pending <= 1'b1;

            if (sweep_go || sweep_empty) begin
                found      <= 1'b0;
                hash_count <= '0;
            end else if (take_hash && hash_count != 32'hFFFF_FFFF) begin
                hash_count <= hash_count + 32'd1;
            end

            if (set_found)
                found <= 1'b1;

            if (sweep_go)
                exhausted <= 1'b0;
            else if (sweep_empty || set_exh)
                exhausted <= 1'b1;

            if (sweep_go) begin
                cur_nonce <= nonce_first;
                last_q    <= nonce_last;
            end else if (step) begin
                cur_nonce <= cur_nonce + 32'd1;
            end

            if (set_found) begin
                win_nonce <= cur_nonce;
                win_hash  <= cmp_hash;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 19; i++) tmpl[i] <= '0;
        end else if (cfg_we && !busy && cfg_addr < HDR_WORDS) begin
            tmpl[cfg_addr] <= cfg_wdata;
        end
    end

`ifdef NONCE_BSWAP_EN
    assign nonce_word = {cur_nonce[7:0], cur_nonce[15:8], cur_nonce[23:16], cur_nonce[31:24]};
`else
    assign nonce_word = cur_nonce;
`endif

    always_comb begin
        word_sel = '0;
        if (core_addr < HDR_WORDS)      word_sel = tmpl[core_addr];
        else if (core_addr == NONCE_IDX) word_sel = nonce_word;
        else if (core_addr == PAD_IDX)   word_sel = PAD_WORD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rdy  <= 1'b0;
            core_data <= '0;
        end else begin
            core_rdy  <= core_rq;
            core_data <= word_sel;
        end
    end

endmodule
